// File: rtl/sd_para_loader.sv
// Loads up to SEG_NUM parameter segments from SD sectors into DDR, packing 16-bit SD words into OUT_W-bit writes.
// Latency: one DDR write one cycle after the SD word that completes a packed group; one SD request per sector.
// Backpressure: none; the DDR FIFO must take one write per SD word, and SD waits are bounded by TIMEOUT.
module sd_para_loader #(
  parameter int SEG_NUM   = 4,
  parameter int OUT_W     = 32,
  parameter int SEC_WORDS = 256,
  parameter int ADDR_W    = 28,
  parameter int CNT_W     = 24,
  parameter int TIMEOUT   = 1000000,
  localparam int IDX_W    = (SEG_NUM > 1) ? $clog2(SEG_NUM) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SEG_NUM-1:0]          seg_en,
  input  logic [SEG_NUM*32-1:0]       seg_sec_base,
  input  logic [SEG_NUM*CNT_W-1:0]    seg_len,
  input  logic [SEG_NUM*ADDR_W-1:0]   seg_ddr_base,
  input  logic                        sd_rd_busy,
  input  logic                        sd_rd_val_en,
  input  logic [15:0]                 sd_rd_val_data,
  output logic                        sd_rd_start_en,
  output logic [31:0]                 sd_rd_sec_addr,
  output logic                        ddr_wr_en,
  output logic [OUT_W-1:0]            ddr_wr_data,
  output logic [ADDR_W-1:0]           ddr_wr_addr,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [IDX_W-1:0]            seg_idx,
  output logic [31:0]                 seg_sum,
  output logic                        seg_sum_vld
);

  localparam int R     = OUT_W / 16;
  localparam int PTR_W = $clog2(SEG_NUM + 1);
  localparam int GRP_W = (R > 1) ? $clog2(R) : 1;
  // Holds the segment's 16-bit word count plus the tail of the last sector (ratio up to 8).
  localparam int WD_W  = CNT_W + 4;

  typedef enum logic [2:0] {IDLE, SEL, REQ, XFER, NXT, FIN} state_t;

  state_t state, state_nxt;

  logic [SEG_NUM-1:0] lat_en;
  logic [31:0]        lat_sec [SEG_NUM];
  logic [CNT_W-1:0]   lat_len [SEG_NUM];
  logic [ADDR_W-1:0]  lat_ddr [SEG_NUM];

  logic [PTR_W-1:0]   seg_ptr;
  logic [WD_W-1:0]    sec_cnt;
  logic [WD_W-1:0]    wd_cnt;
  logic [GRP_W-1:0]   grp_cnt;
  logic [ADDR_W-1:0]  pk_cnt;
  logic [OUT_W-1:0]   pack_buf;
  logic [OUT_W-1:0]   pack_nxt;
  logic [31:0]        sum_acc;
  logic [31:0]        last_sum;
  logic [31:0]        to_cnt;

  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [WD_W-1:0]    need_words;
  logic               seg_complete;
  logic               to_hit;

  assign need_words   = WD_W'(lat_len[seg_idx]) * WD_W'(R);
  // Completion is counted in whole sectors; the tail of the last sector is drained but dropped.
  assign seg_complete = ((sec_cnt + WD_W'(1)) * WD_W'(SEC_WORDS)) >= need_words;
  assign to_hit       = (to_cnt == 32'(TIMEOUT - 1));

  // Lowest enabled, non-empty segment at or after the scan pointer.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = SEG_NUM - 1; i >= 0; i--) begin
      if (i >= int'(seg_ptr) && lat_en[i] && lat_len[i] != '0) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Drop the incoming SD word into its slot of the packing buffer.
  always_comb begin
    pack_nxt = pack_buf;
    for (int k = 0; k < R; k++) begin
      if (grp_cnt == GRP_W'(k)) pack_nxt[16*k +: 16] = sd_rd_val_data;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a timeout in either wait state aborts the whole load.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEL;
      SEL:     state_nxt = sel_found ? REQ : FIN;
      REQ:     if (sd_rd_busy) state_nxt = XFER;
               else if (to_hit) state_nxt = FIN;
      XFER:    if (!sd_rd_busy) state_nxt = NXT;
               else if (to_hit) state_nxt = FIN;
      NXT:     state_nxt = seg_complete ? SEL : REQ;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    sd_rd_start_en = (state == REQ);
    sd_rd_sec_addr = (state == REQ) ? lat_sec[seg_idx] + 32'(sec_cnt) : 32'h0;
    busy           = (state != IDLE) && (state != FIN);
    done           = (state == FIN);
    seg_sum_vld    = (state == NXT) && seg_complete;
    seg_sum        = seg_sum_vld ? sum_acc : last_sum;
  end

  // Descriptor latch, per-segment counters, packing, checksum and timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_en      <= '0;
      for (int i = 0; i < SEG_NUM; i++) begin
        lat_sec[i] <= '0;
        lat_len[i] <= '0;
        lat_ddr[i] <= '0;
      end
      seg_ptr     <= '0;
      seg_idx     <= '0;
      sec_cnt     <= '0;
      wd_cnt      <= '0;
      grp_cnt     <= '0;
      pk_cnt      <= '0;
      pack_buf    <= '0;
      sum_acc     <= '0;
      last_sum    <= '0;
      to_cnt      <= '0;
      err         <= 1'b0;
      ddr_wr_en   <= 1'b0;
      ddr_wr_data <= '0;
      ddr_wr_addr <= '0;
    end else begin
      ddr_wr_en <= 1'b0;

      if (state == IDLE && start) begin
        lat_en  <= seg_en;
        for (int i = 0; i < SEG_NUM; i++) begin
          lat_sec[i] <= seg_sec_base[32*i +: 32];
          lat_len[i] <= seg_len[CNT_W*i +: CNT_W];
          lat_ddr[i] <= seg_ddr_base[ADDR_W*i +: ADDR_W];
        end
        seg_ptr <= '0;
        err     <= 1'b0;
      end

      // Every segment starts with an empty packing buffer and fresh counters.
      if (state == SEL && sel_found) begin
        seg_idx  <= sel_idx;
        seg_ptr  <= PTR_W'(sel_idx) + PTR_W'(1);
        sec_cnt  <= '0;
        wd_cnt   <= '0;
        grp_cnt  <= '0;
        pk_cnt   <= '0;
        pack_buf <= '0;
        sum_acc  <= '0;
      end

      if (state == XFER && sd_rd_val_en) begin
        wd_cnt <= wd_cnt + WD_W'(1);
        if (wd_cnt < need_words) begin
          sum_acc  <= sum_acc + {16'h0, sd_rd_val_data};
          pack_buf <= pack_nxt;
          if (grp_cnt == GRP_W'(R - 1)) begin
            grp_cnt     <= '0;
            ddr_wr_en   <= 1'b1;
            ddr_wr_data <= pack_nxt;
            ddr_wr_addr <= lat_ddr[seg_idx] + pk_cnt;
            pk_cnt      <= pk_cnt + ADDR_W'(1);
          end else begin
            grp_cnt <= grp_cnt + GRP_W'(1);
          end
        end
      end

      if (state == NXT) begin
        if (seg_complete) last_sum <= sum_acc;
        else              sec_cnt  <= sec_cnt + WD_W'(1);
      end

      if ((state == REQ || state == XFER) && state_nxt == FIN) err <= 1'b1;

      if (state_nxt != state)                 to_cnt <= '0;
      else if (state == REQ || state == XFER) to_cnt <= to_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_sd_para_loader.sv
// Directed bench for sd_para_loader: a 16-bit and a 32-bit instance share one SD sector model.
// Expected writes, requests and checksums come from a per-segment model built from the SD word pattern.
// Loads are bounded by a cycle budget; an expired budget is reported as a failed check.
module tb_sd_para_loader;

  localparam int TO = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start16, start32, use32, sd_hang;
  logic [3:0]   seg_en;
  logic [127:0] seg_sec_base;
  logic [95:0]  seg_len;
  logic [111:0] seg_ddr_base;
  logic         sd_rd_busy, sd_rd_val_en;
  logic [15:0]  sd_rd_val_data;

  logic         a_start_en, a_wr_en, a_busy, a_done, a_err, a_sum_vld;
  logic [31:0]  a_sec_addr, a_seg_sum;
  logic [15:0]  a_wr_data;
  logic [27:0]  a_wr_addr;
  logic [1:0]   a_seg_idx;
  logic         b_start_en, b_wr_en, b_busy, b_done, b_err, b_sum_vld;
  logic [31:0]  b_sec_addr, b_seg_sum, b_wr_data;
  logic [27:0]  b_wr_addr;
  logic [1:0]   b_seg_idx;

  sd_para_loader #(.OUT_W(16), .TIMEOUT(TO)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .seg_en(seg_en), .seg_sec_base(seg_sec_base),
    .seg_len(seg_len), .seg_ddr_base(seg_ddr_base), .sd_rd_busy(sd_rd_busy),
    .sd_rd_val_en(sd_rd_val_en), .sd_rd_val_data(sd_rd_val_data),
    .sd_rd_start_en(a_start_en), .sd_rd_sec_addr(a_sec_addr), .ddr_wr_en(a_wr_en),
    .ddr_wr_data(a_wr_data), .ddr_wr_addr(a_wr_addr), .busy(a_busy), .done(a_done),
    .err(a_err), .seg_idx(a_seg_idx), .seg_sum(a_seg_sum), .seg_sum_vld(a_sum_vld));

  sd_para_loader #(.OUT_W(32), .TIMEOUT(TO)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .seg_en(seg_en), .seg_sec_base(seg_sec_base),
    .seg_len(seg_len), .seg_ddr_base(seg_ddr_base), .sd_rd_busy(sd_rd_busy),
    .sd_rd_val_en(sd_rd_val_en), .sd_rd_val_data(sd_rd_val_data),
    .sd_rd_start_en(b_start_en), .sd_rd_sec_addr(b_sec_addr), .ddr_wr_en(b_wr_en),
    .ddr_wr_data(b_wr_data), .ddr_wr_addr(b_wr_addr), .busy(b_busy), .done(b_done),
    .err(b_err), .seg_idx(b_seg_idx), .seg_sum(b_seg_sum), .seg_sum_vld(b_sum_vld));

  // Selected-instance view.
  logic        m_start_en, m_wr_en, m_done, m_err, m_sum_vld, m_zero;
  logic [31:0] m_sec_addr, m_seg_sum, m_wr_data;
  logic [27:0] m_wr_addr;
  logic [1:0]  m_seg_idx;
  logic        z16, z32;
  assign z16 = ~|{a_start_en, a_wr_en, a_busy, a_done, a_err, a_sum_vld, a_sec_addr, a_seg_sum, a_wr_data, a_wr_addr, a_seg_idx};
  assign z32 = ~|{b_start_en, b_wr_en, b_busy, b_done, b_err, b_sum_vld, b_sec_addr, b_seg_sum, b_wr_data, b_wr_addr, b_seg_idx};
  assign m_start_en = use32 ? b_start_en : a_start_en;
  assign m_sec_addr = use32 ? b_sec_addr : a_sec_addr;
  assign m_wr_en    = use32 ? b_wr_en    : a_wr_en;
  assign m_wr_data  = use32 ? b_wr_data  : {16'h0, a_wr_data};
  assign m_wr_addr  = use32 ? b_wr_addr  : a_wr_addr;
  assign m_done     = use32 ? b_done     : a_done;
  assign m_err      = use32 ? b_err      : a_err;
  assign m_sum_vld  = use32 ? b_sum_vld  : a_sum_vld;
  assign m_seg_sum  = use32 ? b_seg_sum  : a_seg_sum;
  assign m_seg_idx  = use32 ? b_seg_idx  : a_seg_idx;
  assign m_zero     = use32 ? z32 : z16;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sd_word(input int sec, input int k);
    return 16'(sec * 256 + k + 1);
  endfunction

  // SD sector model: busy rises on a request, 256 back-to-back words, then busy falls.
  int sd_sec;
  initial begin
    sd_rd_busy = 1'b0; sd_rd_val_en = 1'b0; sd_rd_val_data = 16'h0;
    forever begin
      @(negedge clk);
      if (!sd_hang && m_start_en && !sd_rd_busy) begin
        sd_sec = int'(m_sec_addr);
        sd_rd_busy = 1'b1;
        for (int k = 0; k < 256; k++) begin
          @(negedge clk);
          sd_rd_val_en = 1'b1;
          sd_rd_val_data = sd_word(sd_sec, k);
        end
        @(negedge clk);
        sd_rd_val_en = 1'b0;
        sd_rd_busy = 1'b0;
      end
    end
  end

  // Output monitor.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] got_wr[$], exp_wr[$];
  logic [33:0] got_sum[$], exp_sum[$];
  logic [31:0] got_req[$], exp_req[$];
  int done_cnt, done_cyc, req_cyc;
  logic prev_se = 1'b0;

  always @(negedge clk) begin
    if (m_wr_en)   got_wr.push_back({4'h0, m_wr_addr, m_wr_data});
    if (m_sum_vld) got_sum.push_back({m_seg_idx, m_seg_sum});
    if (m_done) begin done_cnt++; done_cyc = cyc; end
    if (m_start_en && !prev_se) begin got_req.push_back(m_sec_addr); req_cyc = cyc; end
    prev_se = m_start_en;
  end

  task automatic set_seg(input int i, input bit en, input int sec, input int len, input int ddr);
    seg_en[i] = en;
    seg_sec_base[32*i +: 32] = 32'(sec);
    seg_len[24*i +: 24] = 24'(len);
    seg_ddr_base[28*i +: 28] = 28'(ddr);
  endtask

  task automatic new_test();
    exp_wr.delete(); exp_sum.delete(); exp_req.delete();
    seg_en = '0; seg_sec_base = '0; seg_len = '0; seg_ddr_base = '0;
  endtask

  // Expected traffic of one segment: r SD words per DDR word.
  task automatic exp_seg(input int idx, input int sec, input int len, input int ddr, input int r);
    int n;
    logic [31:0] sum, d;
    n = len * r;
    sum = 0;
    for (int w = 0; w < n; w++) sum = sum + 32'(sd_word(sec + w / 256, w % 256));
    for (int j = 0; j < len; j++) begin
      d = 0;
      for (int g = 0; g < r; g++) d = d | (32'(sd_word(sec + (j*r+g) / 256, (j*r+g) % 256)) << (16*g));
      exp_wr.push_back({4'h0, 28'(ddr + j), d});
    end
    for (int s = 0; s < (n + 255) / 256; s++) exp_req.push_back(32'(sec + s));
    exp_sum.push_back({2'(idx), sum});
  endtask

  task automatic pulse_start(input bit is32);
    got_wr.delete(); got_sum.delete(); got_req.delete();
    done_cnt = 0;
    use32 = is32;
    @(negedge clk);
    if (is32) start32 = 1'b1; else start16 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; start16 = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 5000 && done_cnt == 0; i++) @(negedge clk);
    check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic cmp_all(input string tag);
    check({tag, "_nreq"}, 64'(got_req.size()), 64'(exp_req.size()));
    for (int i = 0; i < got_req.size() && i < exp_req.size(); i++)
      check($sformatf("%s_req%0d", tag, i), 64'(got_req[i]), 64'(exp_req[i]));
    check({tag, "_nwr"}, 64'(got_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), got_wr[i], exp_wr[i]);
    check({tag, "_nsum"}, 64'(got_sum.size()), 64'(exp_sum.size()));
    for (int i = 0; i < got_sum.size() && i < exp_sum.size(); i++)
      check($sformatf("%s_sum%0d", tag, i), 64'(got_sum[i]), 64'(exp_sum[i]));
  endtask

  initial begin
    rst = 1'b1; start16 = 1'b0; start32 = 1'b0; use32 = 1'b1; sd_hang = 1'b0;
    new_test();
    repeat (3) @(negedge clk);
    check("rst_zero16", 64'(z16), 64'd1);
    check("rst_zero32", 64'(z32), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_zero16", 64'(z16), 64'd1);
    check("idle_zero32", 64'(z32), 64'd1);

    // 16-bit words, 300 words over two sectors, tail of sector 101 dropped.
    new_test();
    set_seg(0, 1, 100, 300, 0);
    exp_seg(0, 100, 300, 0, 1);
    pulse_start(0);
    wait_done("t1");
    cmp_all("t1");

    // 32-bit words, segments 0 and 2, one sector each.
    new_test();
    set_seg(0, 1, 0, 128, 'h1000);
    set_seg(1, 0, 20, 5, 'h2000);
    set_seg(2, 1, 50, 128, 'h8000);
    set_seg(3, 0, 60, 5, 'h3000);
    exp_seg(0, 0, 128, 'h1000, 2);
    exp_seg(2, 50, 128, 'h8000, 2);
    pulse_start(1);
    wait_done("t2");
    cmp_all("t2");
    if (got_wr.size() > 0) check("t2_first", got_wr[0], {4'h0, 28'h1000, 32'h00020001});

    // All enabled, segment 1 empty; a second start mid-load must be ignored.
    new_test();
    set_seg(0, 1, 10, 7, 'h100);
    set_seg(1, 1, 20, 0, 'h200);
    set_seg(2, 1, 30, 3, 'h300);
    set_seg(3, 1, 40, 130, 'h400);
    exp_seg(0, 10, 7, 'h100, 2);
    exp_seg(2, 30, 3, 'h300, 2);
    exp_seg(3, 40, 130, 'h400, 2);
    pulse_start(1);
    repeat (30) @(negedge clk);
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    wait_done("t3");
    cmp_all("t3");

    // SD never answers: timeout, then a new start clears err.
    new_test();
    set_seg(0, 1, 5, 1, 'h40);
    sd_hang = 1'b1;
    pulse_start(1);
    wait_done("t4");
    check("t4_err", 64'(m_err), 64'd1);
    check("t4_to_window", 64'((done_cyc - req_cyc) >= TO - 2 && (done_cyc - req_cyc) <= TO + 2), 64'd1);
    check("t4_nwr", 64'(got_wr.size()), 64'd0);
    check("t4_nsum", 64'(got_sum.size()), 64'd0);
    sd_hang = 1'b0;
    exp_seg(0, 5, 1, 'h40, 2);
    pulse_start(1);
    check("t4_err_clr", 64'(m_err), 64'd0);
    wait_done("t4b");
    cmp_all("t4b");

    // Reset in the middle of a transfer.
    new_test();
    set_seg(0, 1, 0, 128, 0);
    pulse_start(1);
    for (int i = 0; i < 2000 && got_wr.size() < 10; i++) @(negedge clk);
    check("t5_in_xfer", 64'(got_wr.size() >= 10 && sd_rd_busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_zero", 64'(m_zero), 64'd1);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (!m_zero) bad++;
      end
      check("t5_stay_zero", 64'(bad), 64'd0);
    end
    for (int i = 0; i < 400 && sd_rd_busy; i++) @(negedge clk);
    check("t5_sd_idle", 64'(sd_rd_busy), 64'd0);
    @(negedge clk);

    // DDR address wrap with 16-bit words.
    new_test();
    set_seg(0, 1, 7, 4, (1 << 28) - 2);
    exp_seg(0, 7, 4, (1 << 28) - 2, 1);
    pulse_start(0);
    wait_done("t6");
    cmp_all("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
